// File: rtl/dma_descriptor_scheduler_pkg.sv
// Shared types and helpers for the DMA descriptor scheduler.
package dma_sched_pkg;

    localparam int unsigned PRI_W        = 2;
    localparam int unsigned MAX_PRI_LVLS = 4;
    localparam int unsigned CNT_W        = 9;
    localparam int unsigned WAIT_W       = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_GRANT,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    function automatic logic [7:0] budget_of(input logic [PRI_W-1:0] level,
                                             input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
        case (level)
            2'd0:    return b0;
            2'd1:    return b1;
            2'd2:    return b2;
            default: return b3;
        endcase
    endfunction

endpackage

// File: rtl/dma_descriptor_scheduler_if.sv
// Request/grant/beat handshake between requesters, scheduler and transfer datapath.
interface dma_descriptor_scheduler_if #(
    parameter int unsigned NUM_CH = 4
) ();
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]   req;
    logic [2*NUM_CH-1:0] req_pri;
    logic                grant_valid;
    logic                grant_ready;
    logic [CH_W-1:0]     grant_ch;
    logic [7:0]          grant_len;
    logic                beat;
    logic                xfer_done;
    logic                slice_end;
    logic                done_ch_vld;
    logic [CH_W-1:0]     done_ch;
    logic                busy;

    modport master (
        input  req, req_pri, grant_ready, beat, xfer_done,
        output grant_valid, grant_ch, grant_len, slice_end, done_ch_vld, done_ch, busy
    );

    modport slave (
        output req, req_pri, grant_ready, beat, xfer_done,
        input  grant_valid, grant_ch, grant_len, slice_end, done_ch_vld, done_ch, busy
    );
endinterface

// File: rtl/dma_descriptor_scheduler_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr, wrapping.
module dma_sched_rr_pick #(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] onehot,
    output logic [CH_W-1:0]   idx,
    output logic              found
);
    logic [CH_W:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pos = {1'b0, ptr} + (CH_W+1)'(k);
            if (pos >= (CH_W+1)'(NUM_CH)) pos = pos - (CH_W+1)'(NUM_CH);
            if (!found && mask[pos[CH_W-1:0]]) begin
                found                  = 1'b1;
                idx                    = pos[CH_W-1:0];
                onehot[pos[CH_W-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_descriptor_scheduler.sv
// Time-sliced strict-priority / round-robin scheduler for the shared DMA datapath.
// Optional starvation promotion: define DMA_SCHED_STARVE_PROMOTE_EN.
module dma_descriptor_scheduler
    import dma_sched_pkg::*;
#(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned NUM_PRI_LVLS       = 1,
    parameter int unsigned PRI_0_NUM_OF_BEATS = 255,
    parameter int unsigned PRI_1_NUM_OF_BEATS = 127,
    parameter int unsigned PRI_2_NUM_OF_BEATS = 63,
    parameter int unsigned PRI_3_NUM_OF_BEATS = 31,
    parameter int unsigned STARVE_LIMIT       = 1023
) (
    input logic                        clk,
    input logic                        rst,
    dma_descriptor_scheduler_if.master bus
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 32 || NUM_PRI_LVLS < 1 || NUM_PRI_LVLS > MAX_PRI_LVLS ||
        PRI_0_NUM_OF_BEATS > 255 || PRI_1_NUM_OF_BEATS > 255 || PRI_2_NUM_OF_BEATS > 255 ||
        PRI_3_NUM_OF_BEATS > 255 || STARVE_LIMIT > 1023) begin : g_param_check
        $error("dma_descriptor_scheduler: parameter out of range");
    end

    state_t state, state_nx;

    logic [CH_W-1:0]   grant_ch_q;
    logic [7:0]        grant_len_q;
    logic [PRI_W-1:0]  arb_lvl_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic              slice_end_q;
    logic              done_vld_q;
    logic [CH_W-1:0]   done_ch_q;
    logic [CH_W-1:0]   rr_ptr [MAX_PRI_LVLS];

    logic [PRI_W-1:0]  own_lvl [NUM_CH];
    logic [PRI_W-1:0]  arb_lvl [NUM_CH];
    logic [PRI_W-1:0]  pri;

    logic [NUM_CH-1:0]       lvl_onehot [MAX_PRI_LVLS];
    logic [CH_W-1:0]         lvl_idx    [MAX_PRI_LVLS];
    logic [MAX_PRI_LVLS-1:0] lvl_found;

    logic              win_found;
    logic [PRI_W-1:0]  win_lvl;
    logic [PRI_W-1:0]  win_pri;
    logic [CH_W-1:0]   win_ch;
    logic [NUM_CH-1:0] win_onehot;

    logic any_req;
    logic last_beat;
    logic busy_int;

    assign any_req   = |bus.req;
    assign last_beat = (beat_cnt == {1'b0, grant_len_q});
    assign busy_int  = (state == S_GRANT) || (state == S_ACTIVE);

    always_comb begin
        pri = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pri        = bus.req_pri[PRI_W*i +: PRI_W];
            own_lvl[i] = ({1'b0, pri} >= 3'(NUM_PRI_LVLS)) ? PRI_W'(NUM_PRI_LVLS - 1) : pri;
        end
    end

`ifdef DMA_SCHED_STARVE_PROMOTE_EN
    logic [WAIT_W-1:0] wait_cnt [NUM_CH];
    logic [NUM_CH-1:0] starved;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) wait_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (state == S_ARB && win_onehot[i])
                    wait_cnt[i] <= '0;
                else if (bus.req[i] && !(busy_int && grant_ch_q == CH_W'(i)) &&
                         wait_cnt[i] < WAIT_W'(STARVE_LIMIT))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    // A starved channel competes at level 0 but its budget still follows own_lvl.
    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            starved[i] = (wait_cnt[i] >= WAIT_W'(STARVE_LIMIT));
            arb_lvl[i] = starved[i] ? '0 : own_lvl[i];
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) arb_lvl[i] = own_lvl[i];
    end
`endif

    for (genvar l = 0; l < MAX_PRI_LVLS; l++) begin : g_lvl
        if (l < NUM_PRI_LVLS) begin : g_on
            logic [NUM_CH-1:0] mask;
            always_comb begin
                mask = '0;
                for (int unsigned i = 0; i < NUM_CH; i++)
                    mask[i] = bus.req[i] && (arb_lvl[i] == PRI_W'(l));
            end
            dma_sched_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
                .mask   (mask),
                .ptr    (rr_ptr[l]),
                .onehot (lvl_onehot[l]),
                .idx    (lvl_idx[l]),
                .found  (lvl_found[l])
            );
        end else begin : g_off
            assign lvl_onehot[l] = '0;
            assign lvl_idx[l]    = '0;
            assign lvl_found[l]  = 1'b0;
        end
    end

    always_comb begin
        win_found  = 1'b0;
        win_lvl    = '0;
        win_ch     = '0;
        win_onehot = '0;
        win_pri    = '0;
        for (int unsigned l = 0; l < MAX_PRI_LVLS; l++) begin
            if (!win_found && lvl_found[l]) begin
                win_found  = 1'b1;
                win_lvl    = PRI_W'(l);
                win_ch     = lvl_idx[l];
                win_onehot = lvl_onehot[l];
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (win_onehot[i]) win_pri = own_lvl[i];
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (any_req) state_nx = S_ARB;
            S_ARB:     state_nx = win_found ? S_GRANT : S_IDLE;
            S_GRANT:   if (bus.grant_ready) state_nx = S_ACTIVE;
            S_ACTIVE:  if (bus.xfer_done || (bus.beat && last_beat)) state_nx = S_RELEASE;
            S_RELEASE: state_nx = any_req ? S_ARB : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant_ch_q  <= '0;
            grant_len_q <= '0;
            arb_lvl_q   <= '0;
            beat_cnt    <= '0;
            slice_end_q <= 1'b0;
            done_vld_q  <= 1'b0;
            done_ch_q   <= '0;
            for (int unsigned l = 0; l < MAX_PRI_LVLS; l++) rr_ptr[l] <= '0;
        end else begin
            state       <= state_nx;
            slice_end_q <= 1'b0;
            done_vld_q  <= 1'b0;
            case (state)
                S_ARB: if (win_found) begin
                    grant_ch_q  <= win_ch;
                    arb_lvl_q   <= win_lvl;
                    grant_len_q <= budget_of(win_pri, 8'(PRI_0_NUM_OF_BEATS), 8'(PRI_1_NUM_OF_BEATS),
                                             8'(PRI_2_NUM_OF_BEATS), 8'(PRI_3_NUM_OF_BEATS));
                end
                S_GRANT: if (bus.grant_ready) beat_cnt <= '0;
                S_ACTIVE: begin
                    if (bus.beat && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
                    if (bus.xfer_done) begin
                        done_vld_q <= 1'b1;
                        done_ch_q  <= grant_ch_q;
                    end else if (bus.beat && last_beat) begin
                        slice_end_q <= 1'b1;
                    end
                end
                S_RELEASE:
                    rr_ptr[arb_lvl_q] <= (grant_ch_q == CH_W'(NUM_CH - 1)) ? '0 : grant_ch_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.grant_valid = (state == S_GRANT);
    assign bus.busy        = busy_int;
    assign bus.grant_ch    = grant_ch_q;
    assign bus.grant_len   = grant_len_q;
    assign bus.slice_end   = slice_end_q;
    assign bus.done_ch_vld = done_vld_q;
    assign bus.done_ch     = done_ch_q;
endmodule

// File: tb/tb_dma_descriptor_scheduler.sv
// Directed scoreboard bench for dma_descriptor_scheduler (2 levels, len0=7, len1=3).
module tb_dma_descriptor_scheduler;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned LEN0   = 7;
    localparam int unsigned LEN1   = 3;
    localparam int unsigned LIMIT  = 20;

    typedef struct {
        int unsigned ch;
        int unsigned len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_descriptor_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    dma_descriptor_scheduler #(
        .NUM_CH             (NUM_CH),
        .NUM_PRI_LVLS       (2),
        .PRI_0_NUM_OF_BEATS (LEN0),
        .PRI_1_NUM_OF_BEATS (LEN1),
        .PRI_2_NUM_OF_BEATS (63),
        .PRI_3_NUM_OF_BEATS (31),
        .STARVE_LIMIT       (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_grant(input string tag, input int unsigned lat);
        int unsigned n;
        exp_t e;
        n = 0;
        while (!bus.grant_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, lat);
        if (!bus.grant_valid) return;
        check({tag, " sb_pending"}, 32'(sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, " grant_ch"}, bus.grant_ch, e.ch);
        check({tag, " grant_len"}, bus.grant_len, e.len);
        bus.grant_ready = 1'b1;
        tick();
        bus.grant_ready = 1'b0;
    endtask

    task automatic beats(input string tag, input int unsigned n, input bit done_last, input bit slice_last);
        for (int unsigned k = 0; k < n; k++) begin
            bus.beat      = 1'b1;
            bus.xfer_done = done_last && (k == n - 1);
            tick();
            if (k < n - 1) begin
                check({tag, " early slice_end"}, bus.slice_end, 0);
            end else begin
                check({tag, " slice_end"}, bus.slice_end, slice_last);
                check({tag, " done_ch_vld"}, bus.done_ch_vld, done_last);
            end
        end
        bus.beat      = 1'b0;
        bus.xfer_done = 1'b0;
    endtask

    initial begin
        bit          ch1_seen;
        int unsigned ch1_at;
        logic [7:0]  ch1_len;

        bus.req = '0; bus.req_pri = '0; bus.grant_ready = 1'b0;
        bus.beat = 1'b0; bus.xfer_done = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset grant_valid", bus.grant_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset grant_ch", bus.grant_ch, 0);
        rst = 1'b0;
        tick();

        // Round-robin within level 0
        bus.req = 4'b1111;
        foreach (sb[i]) sb.delete(i);
        sb.push_back('{0, LEN0}); sb.push_back('{1, LEN0}); sb.push_back('{2, LEN0});
        sb.push_back('{3, LEN0}); sb.push_back('{0, LEN0});
        for (int unsigned g = 0; g < 5; g++) begin
            take_grant($sformatf("rr g%0d", g), 2);
            beats($sformatf("rr g%0d", g), 1, 1, 0);
            check($sformatf("rr g%0d done_ch", g), bus.done_ch, g % 4);
        end
        bus.req = '0;

        // Reset in the middle of an active slice
        tick();
        bus.req = 4'b0100;
        sb.push_back('{2, LEN0});
        take_grant("rst_mid", 2);
        bus.req = '0;
        bus.beat = 1'b1;
        tick();
        bus.xfer_done = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.beat = 1'b0; bus.xfer_done = 1'b0;
        check("rst_mid grant_valid", bus.grant_valid, 0);
        check("rst_mid busy", bus.busy, 0);
        check("rst_mid slice_end", bus.slice_end, 0);
        check("rst_mid done_ch_vld", bus.done_ch_vld, 0);
        check("rst_mid grant_ch", bus.grant_ch, 0);
        check("rst_mid grant_len", bus.grant_len, 0);
        tick();
        check("rst_mid idle done_ch_vld", bus.done_ch_vld, 0);
        check("rst_mid idle busy", bus.busy, 0);
        bus.req = 4'b1111;
        sb.push_back('{0, LEN0});
        take_grant("rst_ptr", 2);
        beats("rst_ptr", 1, 1, 0);
        bus.req = '0;
        tick();

        // Slicing: ch2 at level 1, 10 beats
        bus.req = 4'b0100;
        bus.req_pri = 8'b0001_0000;
        sb.push_back('{2, LEN1}); sb.push_back('{2, LEN1}); sb.push_back('{2, LEN1});
        take_grant("slice s1", 2);
        beats("slice s1", 4, 0, 1);
        bus.beat = 1'b1; bus.xfer_done = 1'b1;
        tick();
        tick();
        bus.beat = 1'b0; bus.xfer_done = 1'b0;
        check("ignored beat grant_valid", bus.grant_valid, 1);
        check("ignored beat done_ch_vld", bus.done_ch_vld, 0);
        take_grant("slice s2", 0);
        beats("slice s2", 4, 0, 1);
        take_grant("slice s3", 2);
        beats("slice s3", 2, 0, 0);
        bus.xfer_done = 1'b1;
        tick();
        bus.xfer_done = 1'b0;
        check("slice tail done_ch_vld", bus.done_ch_vld, 1);
        check("slice tail done_ch", bus.done_ch, 2);
        check("slice tail slice_end", bus.slice_end, 0);
        bus.req = '0;
        tick();

        // Higher level arrives while lower level is active
        bus.req = 4'b0010;
        bus.req_pri = 8'b0000_0100;
        sb.push_back('{1, LEN1});
        take_grant("pre ch1", 2);
        bus.req = 4'b1010;
        sb.push_back('{3, LEN0}); sb.push_back('{3, LEN0}); sb.push_back('{1, LEN1});
        beats("pre ch1", 4, 0, 1);
        take_grant("pre ch3a", 2);
        beats("pre ch3a", 1, 1, 0);
        check("pre ch3a done_ch", bus.done_ch, 3);
        take_grant("pre ch3b", 2);
        beats("pre ch3b", 1, 1, 0);
        bus.req = 4'b0010;
        take_grant("pre ch1 again", 2);
        beats("pre ch1 again", 1, 1, 0);
        check("pre ch1 done_ch", bus.done_ch, 1);
        bus.req = '0;
        tick();

        // Clamped priority, last budget beat coincides with done
        bus.req = 4'b0001;
        bus.req_pri = 8'b0000_0011;
        sb.push_back('{0, LEN1});
        take_grant("same_cycle", 2);
        beats("same_cycle", 4, 1, 0);
        check("same_cycle done_ch", bus.done_ch, 0);
        bus.req = '0;
        tick();
        check("same_cycle after done_ch_vld", bus.done_ch_vld, 0);
        check("same_cycle after slice_end", bus.slice_end, 0);
        check("same_cycle after busy", bus.busy, 0);
        tick();
        check("same_cycle idle grant_valid", bus.grant_valid, 0);

        // Starvation: ch0 level 0 continuous, ch1 level 1 waiting
        bus.req = 4'b0011;
        bus.req_pri = 8'b0000_0100;
        ch1_seen = 1'b0; ch1_at = 0; ch1_len = '0;
        for (int unsigned cyc = 0; cyc < 500; cyc++) begin
            if (bus.grant_valid) begin
                bus.grant_ready = 1'b1;
                if (bus.grant_ch == 2'd1 && !ch1_seen) begin
                    ch1_seen = 1'b1;
                    ch1_at   = cyc;
                    ch1_len  = bus.grant_len;
                end
            end else begin
                bus.grant_ready = 1'b0;
            end
            bus.beat = bus.busy && !bus.grant_valid;
            tick();
        end
        bus.req = '0; bus.beat = 1'b0; bus.grant_ready = 1'b0;
`ifdef DMA_SCHED_STARVE_PROMOTE_EN
        check("starve ch1 granted", ch1_seen, 1);
        check("starve ch1 in time", 32'(ch1_at <= LIMIT + LEN0 + 1 + 6), 1);
        check("starve ch1 own budget", ch1_len, LEN1);
`else
        check("starve ch1 never granted", ch1_seen, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
